alu_wordop_seq: RTL and testbench

//  Two-cycle sequencer for the 16-bit ADIW/SBIW instructions on the 8-bit AVR ALU. Accepts one word-op

---
 rtl/alu_wordop_seq_if.sv | 22 ++
 rtl/alu_wordop_seq.sv | 141 ++++++++++++++
 tb/tb_alu_wordop_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wordop_seq_if.sv
// Word-op request channel between the instruction decoder and the ADIW/SBIW sequencer.
interface alu_wordop_seq_if #(
   parameter int unsigned IMM_W = 6
);
   logic             wop_req;
   logic             wop_sub;
   logic [1:0]       wop_pair;
   logic [IMM_W-1:0] wop_k;
   logic             wop_ready;
   logic             wop_busy;
   logic             wop_done;

   modport master (
      output wop_req, wop_sub, wop_pair, wop_k,
      input  wop_ready, wop_busy, wop_done
   );

   modport slave (
      input  wop_req, wop_sub, wop_pair, wop_k,
      output wop_ready, wop_busy, wop_done
   );
endinterface

// File: rtl/alu_wordop_seq.sv
// Two-cycle ADIW/SBIW sequencer: low byte through the 8-bit ALU, then high byte with the
// latched low-byte carry/zero fed back; SREG is committed once at the end.
module alu_wordop_seq #(
   parameter int unsigned REG_BASE = 24,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned IMM_W    = 6
) (
   input  logic              cp2,
   input  logic              rst,
   alu_wordop_seq_if.slave   wop,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [7:0]        rf_rdata,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [7:0]        rf_wdata,
   output logic              rf_we,
   output logic [7:0]        alu_d,
   output logic [7:0]        alu_r,
   output logic              alu_adiw,
   output logic              alu_sbiw,
   output logic              alu_adiw_st,
   output logic              alu_sbiw_st,
   output logic              alu_c_in,
   output logic              alu_z_in,
   input  logic [7:0]        alu_data_out,
   input  logic              alu_c_out,
   input  logic              alu_z_out,
   input  logic              alu_n_out,
   input  logic              alu_v_out,
   input  logic              alu_s_out,
   output logic              sreg_we,
   output logic              sreg_c,
   output logic              sreg_z,
   output logic              sreg_n,
   output logic              sreg_v,
   output logic              sreg_s
);

   typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

   state_e            state_q, state_d;
   logic              sub_q;
   logic [1:0]        pair_q;
   logic [IMM_W-1:0]  k_q;
   logic              c_lo_q, z_lo_q;
   logic [ADDR_W-1:0] lo_addr;
   logic              ready, busy, done;

   assign lo_addr = ADDR_W'(REG_BASE) + ADDR_W'({pair_q, 1'b0});

   always_ff @(posedge cp2) begin
      if (rst) begin
         state_q <= StIdle;
         sub_q   <= 1'b0;
         pair_q  <= '0;
         k_q     <= '0;
         c_lo_q  <= 1'b0;
         z_lo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && wop.wop_req) begin
            sub_q  <= wop.wop_sub;
            pair_q <= wop.wop_pair;
            k_q    <= wop.wop_k;
         end
         // Low-byte flags feed the high-byte step as carry/borrow and zero-chain.
         if (state_q == StLow) begin
            c_lo_q <= alu_c_out;
            z_lo_q <= alu_z_out;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      rf_raddr    = '0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      rf_we       = 1'b0;
      alu_d       = '0;
      alu_r       = '0;
      alu_adiw    = 1'b0;
      alu_sbiw    = 1'b0;
      alu_adiw_st = 1'b0;
      alu_sbiw_st = 1'b0;
      alu_c_in    = 1'b0;
      alu_z_in    = 1'b0;
      sreg_we     = 1'b0;
      sreg_c      = 1'b0;
      sreg_z      = 1'b0;
      sreg_n      = 1'b0;
      sreg_v      = 1'b0;
      sreg_s      = 1'b0;
      case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (wop.wop_req) state_d = StLow;
         end
         StLow: begin
            busy     = 1'b1;
            rf_raddr = lo_addr;
            rf_waddr = lo_addr;
            rf_wdata = alu_data_out;
            rf_we    = 1'b1;
            alu_d    = rf_rdata;
            alu_r    = 8'(k_q);
            alu_adiw = ~sub_q;
            alu_sbiw = sub_q;
            state_d  = StHigh;
         end
         StHigh: begin
            busy        = 1'b1;
            done        = 1'b1;
            rf_raddr    = lo_addr + ADDR_W'(1);
            rf_waddr    = lo_addr + ADDR_W'(1);
            rf_wdata    = alu_data_out;
            rf_we       = 1'b1;
            alu_d       = rf_rdata;
            alu_adiw_st = ~sub_q;
            alu_sbiw_st = sub_q;
            alu_c_in    = c_lo_q;
            alu_z_in    = z_lo_q;
            sreg_we     = 1'b1;
            sreg_c      = alu_c_out;
            sreg_z      = alu_z_out;
            sreg_n      = alu_n_out;
            sreg_v      = alu_v_out;
            sreg_s      = alu_s_out;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign wop.wop_ready = ready;
   assign wop.wop_busy  = busy;
   assign wop.wop_done  = done;

endmodule

// File: tb/tb_alu_wordop_seq.sv
// Bench for alu_wordop_seq: byte-level ALU and register file around the sequencer, checked
// against plain 16-bit ADIW/SBIW arithmetic.
module tb_alu_wordop_seq;

   logic       cp2, rst;
   logic [4:0] rf_raddr, rf_waddr;
   logic [7:0] rf_rdata, rf_wdata, alu_d, alu_r, alu_data_out;
   logic       rf_we, alu_adiw, alu_sbiw, alu_adiw_st, alu_sbiw_st, alu_c_in, alu_z_in;
   logic       alu_c_out, alu_z_out, alu_n_out, alu_v_out, alu_s_out;
   logic       sreg_we, sreg_c, sreg_z, sreg_n, sreg_v, sreg_s;

   alu_wordop_seq_if #(.IMM_W(6)) wif ();

   alu_wordop_seq #(.REG_BASE(24), .ADDR_W(5), .IMM_W(6)) dut (
      .cp2(cp2), .rst(rst), .wop(wif),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_we(rf_we), .alu_d(alu_d), .alu_r(alu_r), .alu_adiw(alu_adiw), .alu_sbiw(alu_sbiw),
      .alu_adiw_st(alu_adiw_st), .alu_sbiw_st(alu_sbiw_st), .alu_c_in(alu_c_in),
      .alu_z_in(alu_z_in), .alu_data_out(alu_data_out), .alu_c_out(alu_c_out),
      .alu_z_out(alu_z_out), .alu_n_out(alu_n_out), .alu_v_out(alu_v_out),
      .alu_s_out(alu_s_out), .sreg_we(sreg_we), .sreg_c(sreg_c), .sreg_z(sreg_z),
      .sreg_n(sreg_n), .sreg_v(sreg_v), .sreg_s(sreg_s)
   );

   initial begin
      cp2 = 1'b0;
      forever #5 cp2 = ~cp2;
   end

   // Byte ALU: add/sub with carry-in; zero-chain only for the high-byte (_st) operations.
   logic [8:0] alu_wide;
   logic       alu_add, alu_any;
   always_comb begin
      alu_add  = alu_adiw | alu_adiw_st;
      alu_any  = alu_add | alu_sbiw | alu_sbiw_st;
      alu_wide = '0;
      if (alu_add) alu_wide = {1'b0, alu_d} + {1'b0, alu_r} + {8'd0, alu_c_in};
      else if (alu_any) alu_wide = {1'b0, alu_d} - {1'b0, alu_r} - {8'd0, alu_c_in};
      alu_data_out = alu_wide[7:0];
      alu_c_out    = alu_any & alu_wide[8];
      alu_z_out    = alu_any & (alu_wide[7:0] == 8'd0) & ((alu_adiw | alu_sbiw) | alu_z_in);
      alu_n_out    = alu_any & alu_wide[7];
      if (alu_add) alu_v_out = (alu_d[7] == alu_r[7]) && (alu_wide[7] != alu_d[7]);
      else alu_v_out = alu_any && (alu_d[7] != alu_r[7]) && (alu_wide[7] != alu_d[7]);
      alu_s_out = alu_n_out ^ alu_v_out;
   end

   // Register file and SREG, with a bench-side preload port.
   logic [7:0] rf [32];
   logic [4:0] sreg_q;
   logic       pl_we, pl_sreg;
   logic [4:0] pl_addr, pl_sreg_val;
   logic [7:0] pl_data;
   int         sreg_pulses;

   assign rf_rdata = rf[rf_raddr];

   always @(posedge cp2) begin
      if (pl_we) rf[pl_addr] <= pl_data;
      else if (rf_we) rf[rf_waddr] <= rf_wdata;
      if (pl_sreg) sreg_q <= pl_sreg_val;
      else if (sreg_we) sreg_q <= {sreg_c, sreg_z, sreg_n, sreg_v, sreg_s};
      if (sreg_we) sreg_pulses <= sreg_pulses + 1;
   end

   int n_cmp, n_err;

   // Returns {result[15:0], C, Z, N, V, S} of the 16-bit op.
   function automatic logic [20:0] ref_op(input logic sub, input logic [15:0] w,
                                          input logic [5:0] k);
      int unsigned wi, ki, ri;
      logic        c, z, n, v;
      wi = w;
      ki = k;
      if (!sub) begin
         ri = wi + ki;
         c  = ri > 65535;
         ri = ri % 65536;
         v  = (wi < 32768) && (ri >= 32768);
      end else begin
         c  = ki > wi;
         ri = (wi + 65536 - ki) % 65536;
         v  = (wi >= 32768) && (ri < 32768);
      end
      z = ri == 0;
      n = ri >= 32768;
      return {ri[15:0], c, z, n, v, n ^ v};
   endfunction

   task automatic preload(input logic [1:0] pair, input logic [15:0] word,
                          input logic [4:0] sreg_init);
      @(negedge cp2);
      pl_we = 1'b1; pl_addr = 5'(24 + 2 * pair); pl_data = word[7:0];
      pl_sreg = 1'b1; pl_sreg_val = sreg_init;
      @(negedge cp2);
      pl_addr = 5'(25 + 2 * pair); pl_data = word[15:8]; pl_sreg = 1'b0;
      @(negedge cp2);
      pl_we = 1'b0;
   endtask

   // Issues one op and reports the resulting word, SREG, accept-to-done latency and SREG pulses.
   task automatic do_op(input logic sub, input logic [1:0] pair, input logic [5:0] k,
                        input logic [15:0] word, output logic [15:0] res,
                        output logic [4:0] flags, output int lat, output int pulses);
      logic [20:0] m;
      int          p0;
      m = ref_op(sub, word, k);
      preload(pair, word, ~m[4:0]);
      p0 = sreg_pulses;
      for (int i = 0; i < 8 && !wif.wop_ready; i++) @(negedge cp2);
      wif.wop_req = 1'b1; wif.wop_sub = sub; wif.wop_pair = pair; wif.wop_k = k;
      lat = -1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge cp2);
         wif.wop_req = 1'b0;
         if (wif.wop_done && lat < 0) lat = i;
      end
      res    = {rf[25 + 2 * pair], rf[24 + 2 * pair]};
      flags  = sreg_q;
      pulses = sreg_pulses - p0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge cp2);
      rst = 1'b0;
      @(negedge cp2);
      n_cmp++;
      if (wif.wop_ready !== 1'b1 || wif.wop_busy !== 1'b0 || wif.wop_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_handshake: ready/busy/done=%b%b%b want 100",
                  wif.wop_ready, wif.wop_busy, wif.wop_done);
      end
      n_cmp++;
      if ({rf_we, sreg_we, rf_raddr, rf_waddr, alu_d, alu_r} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: we=%b sreg_we=%b raddr=%0d waddr=%0d d=%h r=%h want all 0",
                  rf_we, sreg_we, rf_raddr, rf_waddr, alu_d, alu_r);
      end
      n_cmp++;
      if ({alu_adiw, alu_sbiw, alu_adiw_st, alu_sbiw_st, alu_c_in, alu_z_in} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_alu_sel: sel/cin/zin=%b want 000000",
                  {alu_adiw, alu_sbiw, alu_adiw_st, alu_sbiw_st, alu_c_in, alu_z_in});
      end
   endtask

   task automatic test_directed();
      logic        d_sub  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0]  d_pair [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2};
      logic [5:0]  d_k    [5] = '{6'd1, 6'd1, 6'd1, 6'd1, 6'h3f};
      logic [15:0] d_word [5] = '{16'h00ff, 16'hffff, 16'h7fff, 16'h0000, 16'h003f};
      logic [15:0] d_res  [5] = '{16'h0100, 16'h0000, 16'h8000, 16'hffff, 16'h0000};
      logic [4:0]  d_flg  [5] = '{5'b00000, 5'b11000, 5'b00110, 5'b10101, 5'b01000};
      logic [15:0] res;
      logic [4:0]  flags;
      int          lat, pulses;
      for (int i = 0; i < 5; i++) begin
         do_op(d_sub[i], d_pair[i], d_k[i], d_word[i], res, flags, lat, pulses);
         n_cmp++;
         if (res !== d_res[i]) begin
            n_err++;
            $display("FAIL directed%0d_word: got %h want %h", i, res, d_res[i]);
         end
         n_cmp++;
         if (flags !== d_flg[i]) begin
            n_err++;
            $display("FAIL directed%0d_czvns: got %b want %b", i, flags, d_flg[i]);
         end
         n_cmp++;
         if (lat !== 2 || pulses !== 1) begin
            n_err++;
            $display("FAIL directed%0d_timing: latency %0d sreg pulses %0d want 2 and 1",
                     i, lat, pulses);
         end
      end
   endtask

   task automatic test_random();
      logic        sub;
      logic [1:0]  pair;
      logic [5:0]  k;
      logic [15:0] word, res;
      logic [4:0]  flags;
      logic [20:0] m;
      int          lat, pulses;
      for (int i = 0; i < 40; i++) begin
         sub  = 1'($urandom);
         pair = 2'($urandom);
         k    = 6'($urandom);
         case ($urandom_range(0, 3))
            0: word = 16'($urandom_range(0, 63));
            1: word = 16'hffff - 16'($urandom_range(0, 63));
            2: word = 16'h8000 - 16'($urandom_range(0, 63)) + 16'($urandom_range(0, 63));
            default: word = 16'($urandom);
         endcase
         m = ref_op(sub, word, k);
         do_op(sub, pair, k, word, res, flags, lat, pulses);
         n_cmp++;
         if (res !== m[20:5] || flags !== m[4:0] || lat !== 2 || pulses !== 1) begin
            n_err++;
            $display("FAIL random%0d sub=%b pair=%0d k=%h w=%h: got %h/%b lat %0d pulses %0d want %h/%b lat 2 pulses 1",
                     i, sub, pair, k, word, res, flags, lat, pulses, m[20:5], m[4:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [20:0] m;
      int          dones, misplaced, accepts, p0;
      logic [15:0] res;
      preload(2'd0, 16'h00fe, 5'b0);
      dones = 0; misplaced = 0; accepts = 0;
      p0 = sreg_pulses;
      wif.wop_req = 1'b1; wif.wop_sub = 1'b0; wif.wop_pair = 2'd0; wif.wop_k = 6'd1;
      if (wif.wop_ready) accepts++;
      for (int i = 1; i <= 12; i++) begin
         @(negedge cp2);
         if (wif.wop_done) begin
            dones++;
            if (i % 3 != 2) misplaced++;
         end
         if (wif.wop_ready !== (i % 3 == 0)) misplaced++;
         if (i == 12) wif.wop_req = 1'b0;
         else if (wif.wop_ready) accepts++;
      end
      @(negedge cp2);
      m   = ref_op(1'b0, 16'h0101, 6'd1);
      res = {rf[25], rf[24]};
      n_cmp++;
      if (dones !== 4 || accepts !== 4 || misplaced !== 0) begin
         n_err++;
         $display("FAIL b2b_cadence: dones %0d accepts %0d off-cadence %0d want 4 4 0",
                  dones, accepts, misplaced);
      end
      n_cmp++;
      if (res !== 16'h0102 || sreg_q !== m[4:0] || sreg_pulses - p0 !== 4) begin
         n_err++;
         $display("FAIL b2b_result: got %h/%b pulses %0d want 0102/%b pulses 4",
                  res, sreg_q, sreg_pulses - p0, m[4:0]);
      end
   endtask

   task automatic test_reset_in_low();
      int p0, dones;
      preload(2'd0, 16'h12ff, 5'b0);
      p0 = sreg_pulses;
      dones = 0;
      wif.wop_req = 1'b1; wif.wop_sub = 1'b0; wif.wop_pair = 2'd0; wif.wop_k = 6'd1;
      @(negedge cp2);
      wif.wop_req = 1'b0;
      n_cmp++;
      if (wif.wop_busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd24) begin
         n_err++;
         $display("FAIL rst_low_entry: busy %b we %b waddr %0d want 1 1 24",
                  wif.wop_busy, rf_we, rf_waddr);
      end
      rst = 1'b1;
      @(negedge cp2);
      rst = 1'b0;
      n_cmp++;
      if (wif.wop_ready !== 1'b1 || wif.wop_busy !== 1'b0 || rf_we !== 1'b0 ||
          sreg_we !== 1'b0 || wif.wop_done !== 1'b0) begin
         n_err++;
         $display("FAIL rst_low_after: ready %b busy %b we %b sreg_we %b done %b want 1 0 0 0 0",
                  wif.wop_ready, wif.wop_busy, rf_we, sreg_we, wif.wop_done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge cp2);
         if (wif.wop_done) dones++;
      end
      n_cmp++;
      if (rf[25] !== 8'h12 || sreg_pulses - p0 !== 0 || dones !== 0) begin
         n_err++;
         $display("FAIL rst_low_abort: R25 %h sreg pulses %0d dones %0d want 12 0 0",
                  rf[25], sreg_pulses - p0, dones);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; sreg_pulses = 0;
      pl_we = 1'b0; pl_sreg = 1'b0; pl_addr = '0; pl_data = '0; pl_sreg_val = '0;
      sreg_q = '0;
      for (int i = 0; i < 32; i++) rf[i] = 8'($urandom);
      wif.wop_req = 1'b0; wif.wop_sub = 1'b0; wif.wop_pair = '0; wif.wop_k = '0;
      rst = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_in_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
